// File: rtl/record_fifo_pkg.sv
// Shared types and parameter helpers for record_fifo.
package record_fifo_pkg;

  // Width of the rejected-write counter.
  typedef logic [15:0] drop_count_t;

  localparam drop_count_t DROP_COUNT_MAX = 16'hFFFF;

  // True when v is a nonzero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/record_fifo_mem.sv
// Storage array for record_fifo. Words are written one at a time at a
// word index. Reads return one whole record, selected by record index,
// with word 0 in the LSBs.
module record_fifo_mem
  import record_fifo_pkg::*;
#(
  parameter int WordSize    = 8,
  parameter int RecordWords = 16,
  parameter int Depth       = 8
) (
  input  logic                                         clk,
  input  logic                                         we,
  input  logic [$clog2(Depth*RecordWords)-1:0]         waddr,
  input  logic [WordSize-1:0]                          wdata,
  input  logic [$clog2(Depth)-1:0]                     raddr,
  output logic [WordSize*RecordWords-1:0]              rdata
);

  localparam int LOG_RW = $clog2(RecordWords);
  localparam int CAP    = Depth * RecordWords;

  logic [WordSize-1:0] mem_q [CAP];

  // Word-granular write port; storage is not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Gather the words of the addressed record into one wide bus.
  always_comb begin
    rdata = '0;
    for (int r = 0; r < RecordWords; r++) begin
      rdata[r*WordSize +: WordSize] = mem_q[{raddr, LOG_RW'(r)}];
    end
  end

endmodule

// File: rtl/record_fifo.sv
// record_fifo: assembles WordSize-bit words into RecordWords-word records
// and hands complete records out through a registered valid/ready stage.
// Optional feature: define RECORD_FIFO_DROP_COUNT_EN to build the
// saturating counter of rejected writes; otherwise drop_count is 0.
module record_fifo
  import record_fifo_pkg::*;
#(
  parameter int WordSize          = 8,
  parameter int RecordWords       = 16,
  parameter int Depth             = 8,
  parameter int AlmostFullRecords = Depth - 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [WordSize-1:0]                in_data,
  input  logic                               in_abort,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WordSize*RecordWords-1:0]    out_data,
  output logic [$clog2(Depth):0]             records,
  output logic [$clog2(RecordWords)-1:0]     partial_words,
  output logic                               almost_full,
  output drop_count_t                        drop_count
);

  localparam int LOG_RW  = $clog2(RecordWords);
  localparam int LOG_D   = $clog2(Depth);
  localparam int LOG_CAP = LOG_RW + LOG_D;
  localparam int CAP     = Depth * RecordWords;
  localparam int PW      = LOG_CAP + 1;  // word pointer incl. wrap bit
  localparam int RPW     = LOG_D + 1;    // record pointer incl. wrap bit

  if (!is_pow2(RecordWords) || RecordWords < 2) begin : g_bad_record_words
    $error("record_fifo: RecordWords must be a power of 2 and >= 2");
  end
  if (!is_pow2(Depth) || Depth < 2) begin : g_bad_depth
    $error("record_fifo: Depth must be a power of 2 and >= 2");
  end

  logic [PW-1:0]                   wptr_q, wptr_d;
  logic [RPW-1:0]                  rptr_q, rptr_d;
  logic                            out_valid_q, out_valid_d;
  logic [WordSize*RecordWords-1:0] out_data_q, out_data_d;
  logic [PW-1:0]                   used_words;
  logic [RPW-1:0]                  rec_count;
  logic [WordSize*RecordWords-1:0] rd_record;
  logic                            wr_en;
  logic                            pop;

  // Occupancy derives purely from the pointer registers, so in_ready has
  // no combinational dependence on in_valid or out_ready. Partial words
  // count against capacity; records only count once their last word lands.
  assign used_words    = wptr_q - {rptr_q, {LOG_RW{1'b0}}};
  assign rec_count     = wptr_q[PW-1:LOG_RW] - rptr_q;
  assign in_ready      = (used_words < PW'(CAP));
  assign records       = rec_count;
  assign partial_words = wptr_q[LOG_RW-1:0];
  assign almost_full   = (rec_count >= RPW'(AlmostFullRecords));
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;

  assign wr_en = in_valid && in_ready && !in_abort;
  assign pop   = (rec_count != '0) && (!out_valid_q || out_ready);

  record_fifo_mem #(
    .WordSize   (WordSize),
    .RecordWords(RecordWords),
    .Depth      (Depth)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wptr_q[LOG_CAP-1:0]),
    .wdata(in_data),
    .raddr(rptr_q[LOG_D-1:0]),
    .rdata(rd_record)
  );

  // Pointer and output-register next state. Abort rewinds the write
  // pointer to the record boundary and discards any word offered with it.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_abort) begin
      wptr_d = {wptr_q[PW-1:LOG_RW], {LOG_RW{1'b0}}};
    end else if (wr_en) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d      = rptr_q + RPW'(1);
      out_valid_d = 1'b1;
      out_data_d  = rd_record;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer and output-register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef RECORD_FIFO_DROP_COUNT_EN
  drop_count_t drop_q, drop_d;

  // Count cycles where a word is offered but refused; abort cycles are
  // intentional discards, not drops. Saturates instead of wrapping.
  always_comb begin
    drop_d = drop_q;
    if (in_valid && !in_ready && !in_abort && (drop_q != DROP_COUNT_MAX)) begin
      drop_d = drop_q + drop_count_t'(1);
    end
  end

  // Drop counter register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_record_fifo.sv
// Self-checking bench for record_fifo (WordSize=8, RecordWords=4, Depth=4)
// against a queue-based behavioural model.
module tb_record_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  records;
  logic [1:0]  partial_words;
  logic        almost_full;
  logic [15:0] drop_count;

  int total = 0;
  int bad = 0;

  // Behavioural model: complete records waiting, words of the record
  // being assembled, and the output register.
  logic [31:0] mq[$];
  logic [7:0]  mp[$];
  logic        m_ov;
  logic [31:0] m_od;
  int          m_drops;

  always #5 clk = ~clk;

  record_fifo #(
    .WordSize(8), .RecordWords(4), .Depth(4), .AlmostFullRecords(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_abort(in_abort), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .records(records),
    .partial_words(partial_words), .almost_full(almost_full),
    .drop_count(drop_count)
  );

  function automatic bit m_ready();
    return (mq.size() * 4 + mp.size()) < 16;
  endfunction

  function automatic int exp_drop();
`ifdef RECORD_FIFO_DROP_COUNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] seq_rec(input int k);
    logic [7:0] b;
    b = 8'h20 + 8'(4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, and
  // leave the bench 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic ab, input logic ordy);
    logic        rdy;
    logic [31:0] rec;
    in_valid = v; in_data = d; in_abort = ab; out_ready = ordy;
    rdy = m_ready();
    @(posedge clk);
    if (mq.size() > 0 && (!m_ov || ordy)) begin
      m_od = mq.pop_front();
      m_ov = 1'b1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (ab) begin
      mp.delete();
    end else if (v && rdy) begin
      mp.push_back(d);
      if (mp.size() == 4) begin
        rec = {mp[3], mp[2], mp[1], mp[0]};
        mq.push_back(rec);
        mp.delete();
      end
    end
    if (v && !rdy && !ab && m_drops < 65535) m_drops++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_abort = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); mp.delete();
    m_ov = 1'b0; m_od = '0; m_drops = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 ||
        records !== 3'd0 || partial_words !== 2'd0 || almost_full !== 1'b0 ||
        drop_count !== 16'd0) begin
      bad++;
      $display("FAIL reset: ov=%0b od=%h rdy=%0b rec=%0d part=%0d af=%0b drop=%0d want 0,0,1,0,0,0,0",
               out_valid, out_data, in_ready, records, partial_words, almost_full, drop_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1);
    step(1, 8'h04, 0, 1);
    total++;
    if (out_valid !== 1'b0 || records !== 3'd1) begin
      bad++;
      $display("FAIL basic_commit: ov=%0b rec=%0d want ov=0 rec=1", out_valid, records);
    end
    step(0, 8'h00, 0, 1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h04030201 || records !== 3'd0) begin
      bad++;
      $display("FAIL basic_out: ov=%0b od=%h rec=%0d want ov=1 od=04030201 rec=0",
               out_valid, out_data, records);
    end
  endtask

  task automatic test_fill();
    int acc;
    do_reset();
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      if (in_ready === 1'b1) acc++;
      step(1, 8'(8'h20 + i), 0, 0);
    end
    total++;
    if (acc != 20 || in_ready !== 1'b0 || records !== 3'd4 || almost_full !== 1'b1) begin
      bad++;
      $display("FAIL fill: acc=%0d rdy=%0b rec=%0d af=%0b want acc=20 rdy=0 rec=4 af=1",
               acc, in_ready, records, almost_full);
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== seq_rec(0)) begin
      bad++;
      $display("FAIL fill_hold: ov=%0b od=%h want ov=1 od=%h", out_valid, out_data, seq_rec(0));
    end
    total++;
    if (drop_count !== 16'(exp_drop())) begin
      bad++;
      $display("FAIL fill_drop: got %0d want %0d", drop_count, exp_drop());
    end
  endtask

  task automatic test_drop_and_drain();
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'hEE, 0, 0);
    total++;
`ifdef RECORD_FIFO_DROP_COUNT_EN
    if (drop_count !== 16'd3) begin
      bad++;
      $display("FAIL drop_count: got %0d want 3", drop_count);
    end
`else
    if (drop_count !== 16'd0) begin
      bad++;
      $display("FAIL drop_count: got %0d want 0", drop_count);
    end
`endif
    total++;
    if (out_data !== seq_rec(0) || records !== 3'd4) begin
      bad++;
      $display("FAIL drain_start: od=%h rec=%0d want od=%h rec=4", out_data, records, seq_rec(0));
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 1);
      total++;
      if (i < 4) begin
        if (out_valid !== 1'b1 || out_data !== seq_rec(i + 1) || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL drain_%0d: ov=%0b od=%h rdy=%0b want ov=1 od=%h rdy=1",
                   i, out_valid, out_data, in_ready, seq_rec(i + 1));
        end
      end else if (out_valid !== 1'b0 || records !== 3'd0) begin
        bad++;
        $display("FAIL drain_end: ov=%0b rec=%0d want ov=0 rec=0", out_valid, records);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    step(1, 8'hCC, 0, 1);
    total++;
    if (partial_words !== 2'd3) begin
      bad++;
      $display("FAIL abort_pre: part=%0d want 3", partial_words);
    end
    step(1, 8'hDD, 1, 1);
    total++;
    if (partial_words !== 2'd0 || records !== 3'd0 || drop_count !== 16'd0) begin
      bad++;
      $display("FAIL abort: part=%0d rec=%0d drop=%0d want 0,0,0", partial_words, records, drop_count);
    end
    step(0, 8'h00, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h11 + i), 0, 1);
    step(0, 8'h00, 0, 1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h14131211) begin
      bad++;
      $display("FAIL abort_next: ov=%0b od=%h want ov=1 od=14131211", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 8'h91, 0, 0);
    step(1, 8'h92, 0, 0);
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 ||
        records !== 3'd0 || partial_words !== 2'd0 || almost_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: ov=%0b od=%h rdy=%0b rec=%0d part=%0d af=%0b want 0,0,1,0,0,0",
               out_valid, out_data, in_ready, records, partial_words, almost_full);
    end
    for (int i = 0; i < 4; i++) step(1, 8'(8'h51 + i), 0, 1);
    step(0, 8'h00, 0, 1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h54535251) begin
      bad++;
      $display("FAIL reset_mid_rec: ov=%0b od=%h want ov=1 od=54535251", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 20) == 0, ($urandom % 3) != 0);
      total++;
      if (out_valid !== m_ov || (m_ov && out_data !== m_od) || in_ready !== m_ready() ||
          records !== 3'(mq.size()) || partial_words !== 2'(mp.size()) ||
          almost_full !== (mq.size() >= 3) || drop_count !== 16'(exp_drop())) begin
        bad++;
        $display("FAIL random_c%0d: ov=%0b od=%h rdy=%0b rec=%0d part=%0d af=%0b drop=%0d want %0b %h %0b %0d %0d %0b %0d",
                 c, out_valid, out_data, in_ready, records, partial_words, almost_full, drop_count,
                 m_ov, m_od, m_ready(), mq.size(), mp.size(), mq.size() >= 3, exp_drop());
      end
    end
  endtask

  initial begin
    m_ov = 1'b0; m_od = '0; m_drops = 0;
    #1;
    test_reset();
    test_basic();
    test_fill();
    test_drop_and_drain();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
